ifu_fetch: RTL and testbench

Instruction fetch unit sitting directly downstream of the program counter stage in the NPC core. It accepts one PC at a time over a valid/ready handshake, issues a word read to instruction memory, and waits a variable number of cycles for the response. It then holds the instruction, its PC and a fault code for the decode stage until decode accepts it. It also supports flush/redirect and bounds memory latency with a timeout.

---
 rtl/ifu_pkg.sv | 33 +++
 rtl/ifu_timeout_cnt.sv | 39 +++
 rtl/ifu_fetch.sv | 153 +++++++++++++++
 tb/tb_ifu_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, fault codes, reset PC and the nop word
//                presented on faulted fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_OUT  = 3'd3,
        IFU_DROP = 3'd4
    } ifu_state_t;

    localparam logic [1:0]  IFU_FAULT_NONE     = 2'd0;
    localparam logic [1:0]  IFU_FAULT_MISALIGN = 2'd1;
    localparam logic [1:0]  IFU_FAULT_BUSERR   = 2'd2;
    localparam logic [1:0]  IFU_FAULT_TIMEOUT  = 2'd3;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    // A fetch address must be word aligned.
    function automatic logic ifu_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_timeout_cnt
//  Description : 16-bit saturating cycle counter bounding a memory wait
//                window. Shared by the WAIT and DROP windows of ifu_fetch.
//  Ports       : clk, rst (async, active-high)
//                clear   - restart the window (priority over enable)
//                enable  - count this cycle
//                expired - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] c_LAST_COUNT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired = (r_count == c_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit. Accepts one PC over valid/ready,
//                issues a single word read, waits for the response (bounded
//                by TIMEOUT) and holds instruction, PC and fault for decode.
//                Supports flush/redirect; at most one request outstanding.
//  Ports       : clk, rst (async, active-high)
//                pc_valid/pc_ready/pc_addr      - PC stage handshake
//                flush                          - abandon current fetch
//                mem_req/mem_addr/mem_gnt       - memory request channel
//                mem_rvalid/mem_rdata/mem_rerr  - memory response channel
//                inst_valid/inst_ready/inst/inst_pc/inst_fault - to decode
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc_addr,
    output logic        pc_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    input  logic        inst_ready
);

    ifu_state_t  r_state;
    logic        r_pending;     // DROP must present the timeout fault afterwards
    logic [31:0] r_mem_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [1:0]  r_fault;

    logic        w_cnt_clear;
    logic        w_cnt_enable;
    logic        w_expired;

    // Handshake/request outputs are decoded from the state register only;
    // pc_ready additionally masks the accept while a flush is asserted.
    assign pc_ready   = (r_state == IFU_IDLE) && !flush;
    assign mem_req    = (r_state == IFU_REQ);
    assign inst_valid = (r_state == IFU_OUT);
    assign mem_addr   = r_mem_addr;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_fault = r_fault;

    // The counter restarts on every entry into WAIT or DROP.
    always_comb begin
        w_cnt_clear  = 1'b0;
        w_cnt_enable = (r_state == IFU_WAIT) || (r_state == IFU_DROP);
        case (r_state)
            IFU_REQ:  w_cnt_clear = mem_gnt;
            IFU_WAIT: w_cnt_clear = !mem_rvalid && (flush || w_expired);
            default:  w_cnt_clear = 1'b0;
        endcase
    end

    ifu_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IFU_IDLE;
            r_pending  <= 1'b0;
            r_mem_addr <= IFU_RESET_PC;
            r_inst     <= IFU_NOP;
            r_inst_pc  <= IFU_RESET_PC;
            r_fault    <= IFU_FAULT_NONE;
        end else begin
            case (r_state)
                IFU_IDLE: begin
                    if (pc_valid && pc_ready) begin
                        r_inst_pc  <= pc_addr;
                        r_mem_addr <= {pc_addr[31:2], 2'b00};
                        if (ifu_misaligned(pc_addr)) begin
                            r_inst  <= IFU_NOP;
                            r_fault <= IFU_FAULT_MISALIGN;
                            r_state <= IFU_OUT;
                        end else begin
                            r_fault <= IFU_FAULT_NONE;
                            r_state <= IFU_REQ;
                        end
                    end
                end
                IFU_REQ: begin
                    // A response in the grant cycle is illegal and ignored.
                    if (flush) begin
                        r_pending <= 1'b0;
                        r_state   <= mem_gnt ? IFU_DROP : IFU_IDLE;
                    end else if (mem_gnt) begin
                        r_state <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (flush) begin
                        r_pending <= 1'b0;
                        r_state   <= mem_rvalid ? IFU_IDLE : IFU_DROP;
                    end else if (mem_rvalid) begin
                        r_inst  <= mem_rerr ? IFU_NOP : mem_rdata;
                        r_fault <= mem_rerr ? IFU_FAULT_BUSERR : IFU_FAULT_NONE;
                        r_state <= IFU_OUT;
                    end else if (w_expired) begin
                        // Still owe the orphaned response: drain it, then report.
                        r_inst    <= IFU_NOP;
                        r_fault   <= IFU_FAULT_TIMEOUT;
                        r_pending <= 1'b1;
                        r_state   <= IFU_DROP;
                    end
                end
                IFU_OUT: begin
                    if (flush || inst_ready) begin
                        r_state <= IFU_IDLE;
                    end
                end
                IFU_DROP: begin
                    if (flush) begin
                        r_pending <= 1'b0;
                    end
                    if (mem_rvalid || w_expired) begin
                        r_state   <= (r_pending && !flush) ? IFU_OUT : IFU_IDLE;
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Self-checking bench for ifu_fetch: per-cycle vector table,
//                directed multi-cycle sequences (timeout, flush, reset) and
//                a randomized phase scored against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam int unsigned T = 4;
    localparam logic [31:0] A = 32'h8000_0000;
    localparam logic [31:0] B = 32'h8000_0104;
    localparam logic [31:0] P = 32'h8000_0200;
    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid, flush, mem_gnt, mem_rvalid, mem_rerr, inst_ready;
    logic [31:0] pc_addr, mem_rdata;
    logic        pc_ready, mem_req, inst_valid;
    logic [31:0] mem_addr, inst, inst_pc;
    logic [1:0]  inst_fault;

    int total = 0;
    int bad   = 0;

    ifu_fetch #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_valid   (pc_valid),
        .pc_addr    (pc_addr),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rerr   (mem_rerr),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    // ctl = {pc_valid, flush, mem_gnt, mem_rvalid, mem_rerr, inst_ready}
    // ex  = {pc_ready, mem_req, inst_valid}; data checked only when valid/req
    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] pa;
        logic [31:0] rd;
        logic [2:0]  ex;
        logic [31:0] maddr;
        logic [31:0] einst;
        logic [31:0] epc;
        logic [1:0]  eflt;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  flt;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];

    function automatic vec_t row(input logic [5:0] ctl, input logic [31:0] pa,
                                 input logic [31:0] rd, input logic [2:0] ex,
                                 input logic [31:0] maddr, input logic [31:0] einst,
                                 input logic [31:0] epc, input logic [1:0] eflt);
        vec_t v;
        v.ctl = ctl; v.pa = pa; v.rd = rd; v.ex = ex;
        v.maddr = maddr; v.einst = einst; v.epc = epc; v.eflt = eflt;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic clr_in();
        pc_valid = 1'b0; pc_addr = '0; flush = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] ei,
                           input logic [31:0] ep, input logic [1:0] ef);
        chk1({name, " inst_valid"}, inst_valid, 1'b1);
        chk32({name, " inst"}, inst, ei);
        chk32({name, " inst_pc"}, inst_pc, ep);
        chk32({name, " fault"}, {30'd0, inst_fault}, {30'd0, ef});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rcnt;
        int          gcnt;
        bit          req_seen;
        int          k;
        bit          r_err;
        logic [31:0] r_data;
        logic [31:0] acc_pc;
        int          outs;
        exp_t        e;

        // ---------------- reset ----------------
        clr_in();
        rst = 1'b1;
        tick();
        chk1("rst pc_ready", pc_ready, 1'b1);
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst inst_valid", inst_valid, 1'b0);
        chk32("rst mem_addr", mem_addr, A);
        chk32("rst inst", inst, N);
        chk32("rst inst_pc", inst_pc, A);
        chk32("rst fault", {30'd0, inst_fault}, 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- vector table ----------------
        tbl.push_back(row(6'b100001, A,  0,            3'b100, 0, 0, 0, 2'd0));  // accept aligned
        tbl.push_back(row(6'b001001, 0,  0,            3'b010, A, 0, 0, 2'd0));  // gnt
        tbl.push_back(row(6'b000101, 0,  32'h297,      3'b000, 0, 0, 0, 2'd0));  // rvalid
        tbl.push_back(row(6'b000001, 0,  0,            3'b001, 0, 32'h297, A, 2'd0));
        tbl.push_back(row(6'b000000, 0,  0,            3'b100, 0, 0, 0, 2'd0));  // pc_ready back
        tbl.push_back(row(6'b100000, A + 32'd2, 0,     3'b100, 0, 0, 0, 2'd0));  // misaligned
        tbl.push_back(row(6'b000001, 0,  0,            3'b001, 0, N, A + 32'd2, 2'd1));
        tbl.push_back(row(6'b000000, 0,  0,            3'b100, 0, 0, 0, 2'd0));
        tbl.push_back(row(6'b100000, B,  0,            3'b100, 0, 0, 0, 2'd0));  // accept B
        tbl.push_back(row(6'b000000, 0,  0,            3'b010, B, 0, 0, 2'd0));  // gnt stall x3
        tbl.push_back(row(6'b000000, 0,  0,            3'b010, B, 0, 0, 2'd0));
        tbl.push_back(row(6'b000000, 0,  0,            3'b010, B, 0, 0, 2'd0));
        tbl.push_back(row(6'b001000, 0,  0,            3'b010, B, 0, 0, 2'd0));
        tbl.push_back(row(6'b000000, 0,  0,            3'b000, 0, 0, 0, 2'd0));
        tbl.push_back(row(6'b000110, 0,  32'hFFFF_FFFF, 3'b000, 0, 0, 0, 2'd0)); // bus error
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(6'b000000, 0, 0,         3'b001, 0, N, B, 2'd2));  // backpressure
        tbl.push_back(row(6'b000001, 0,  0,            3'b001, 0, N, B, 2'd2));
        tbl.push_back(row(6'b110000, P,  0,            3'b000, 0, 0, 0, 2'd0));  // flush in IDLE
        tbl.push_back(row(6'b000000, 0,  0,            3'b100, 0, 0, 0, 2'd0));
        tbl.push_back(row(6'b100000, P,  0,            3'b100, 0, 0, 0, 2'd0));
        tbl.push_back(row(6'b010000, 0,  0,            3'b010, P, 0, 0, 2'd0));  // flush in REQ
        tbl.push_back(row(6'b000000, 0,  0,            3'b100, 0, 0, 0, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            {pc_valid, flush, mem_gnt, mem_rvalid, mem_rerr, inst_ready} = tbl[i].ctl;
            pc_addr   = tbl[i].pa;
            mem_rdata = tbl[i].rd;
            #1;
            chk1($sformatf("row%0d pc_ready", i), pc_ready, tbl[i].ex[2]);
            chk1($sformatf("row%0d mem_req", i), mem_req, tbl[i].ex[1]);
            chk1($sformatf("row%0d inst_valid", i), inst_valid, tbl[i].ex[0]);
            if (tbl[i].ex[1])
                chk32($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].maddr);
            if (tbl[i].ex[0])
                chk_out($sformatf("row%0d", i), tbl[i].einst, tbl[i].epc, tbl[i].eflt);
            tick();
        end
        clr_in();

        // ---------------- timeout: no response for T WAIT cycles ----------------
        pc_valid = 1'b1; pc_addr = 32'h8000_0300; tick(); clr_in();
        mem_gnt = 1'b1; tick(); clr_in();
        for (int i = 0; i < int'(T); i++) begin
            #1; chk1($sformatf("to wait%0d inst_valid", i), inst_valid, 1'b0); tick();
        end
        #1; chk1("to drop inst_valid", inst_valid, 1'b0);
        chk1("to drop pc_ready", pc_ready, 1'b0); tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk1("to late inst_valid", inst_valid, 1'b0); tick(); clr_in();
        #1; chk_out("to out", N, 32'h8000_0300, 2'd3);
        inst_ready = 1'b1; tick(); clr_in();
        #1; chk1("to after pc_ready", pc_ready, 1'b1); tick();

        // ---------------- flush in WAIT ----------------
        pc_valid = 1'b1; pc_addr = 32'h8000_0400; tick(); clr_in();
        mem_gnt = 1'b1; tick(); clr_in();
        flush = 1'b1; #1; chk1("fl wait inst_valid", inst_valid, 1'b0); tick(); clr_in();
        #1; chk1("fl drop pc_ready", pc_ready, 1'b0); tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        chk1("fl orphan inst_valid", inst_valid, 1'b0); tick(); clr_in();
        #1; chk1("fl idle pc_ready", pc_ready, 1'b1);
        chk1("fl idle inst_valid", inst_valid, 1'b0);
        pc_valid = 1'b1; pc_addr = 32'h8000_0010; tick(); clr_in();
        mem_gnt = 1'b1; tick(); clr_in();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0517; tick(); clr_in();
        #1; chk_out("fl next", 32'h0000_0517, 32'h8000_0010, 2'd0);
        inst_ready = 1'b1; tick(); clr_in();

        // ---------------- reset mid-fetch ----------------
        pc_valid = 1'b1; pc_addr = 32'h8000_0500; tick(); clr_in();
        mem_gnt = 1'b1; tick(); clr_in();
        rst = 1'b1; #1;
        chk1("mid rst pc_ready", pc_ready, 1'b1);
        chk1("mid rst mem_req", mem_req, 1'b0);
        chk1("mid rst inst_valid", inst_valid, 1'b0);
        chk32("mid rst mem_addr", mem_addr, A);
        chk32("mid rst inst", inst, N);
        chk32("mid rst inst_pc", inst_pc, A);
        chk32("mid rst fault", {30'd0, inst_fault}, 32'd0);
        tick(); rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; tick(); clr_in();
        for (int i = 0; i < 3; i++) begin
            #1; chk1($sformatf("mid stray%0d inst_valid", i), inst_valid, 1'b0);
            chk1($sformatf("mid stray%0d pc_ready", i), pc_ready, 1'b1); tick();
        end

        // ---------------- randomized phase ----------------
        rcnt = -1; gcnt = 0; req_seen = 1'b0; outs = 0; acc_pc = '0;
        k = 0; r_err = 1'b0; r_data = '0;
        for (int cyc = 0; cyc < 6000 && outs < 80; cyc++) begin
            clr_in();
            mem_rdata = $urandom;
            mem_rerr  = 1'($urandom_range(0, 1));
            if (rcnt == 0) begin
                mem_rvalid = 1'b1; mem_rdata = r_data; mem_rerr = r_err; rcnt = -1;
            end else if (rcnt > 0) begin
                rcnt--;
            end
            if (mem_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    gcnt = $urandom_range(0, 3);
                    chk32("rnd mem_addr", mem_addr, acc_pc);
                end
                if (gcnt == 0) begin
                    mem_gnt  = 1'b1;
                    req_seen = 1'b0;
                    k        = $urandom_range(0, 2 * T - 1);
                    r_err    = ($urandom_range(0, 3) == 0);
                    r_data   = $urandom;
                    rcnt     = k;
                    e.pc     = acc_pc;
                    if (k >= int'(T)) begin
                        e.inst = N; e.flt = IFU_FAULT_TIMEOUT;
                    end else if (r_err) begin
                        e.inst = N; e.flt = IFU_FAULT_BUSERR;
                    end else begin
                        e.inst = r_data; e.flt = IFU_FAULT_NONE;
                    end
                    q.push_back(e);
                end else begin
                    gcnt--;
                end
            end
            pc_valid = ($urandom_range(0, 2) != 0);
            pc_addr  = $urandom;
            if ($urandom_range(0, 3) != 0) pc_addr[1:0] = 2'b00;
            inst_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (pc_valid && pc_ready) begin
                acc_pc = pc_addr;
                if (pc_addr[1:0] != 2'b00) begin
                    e.inst = N; e.pc = pc_addr; e.flt = IFU_FAULT_MISALIGN;
                    q.push_back(e);
                end
            end
            if (inst_valid) begin
                if (q.size() == 0) begin
                    chk1("rnd spurious inst_valid", inst_valid, 1'b0);
                end else if (inst_ready) begin
                    e = q.pop_front();
                    chk_out("rnd", e.inst, e.pc, e.flt);
                    outs++;
                end
            end
            tick();
        end
        clr_in();
        chk32("rnd outputs delivered", outs, 32'd80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
